// File: rtl/e_level_pkg.sv
// Shared E-stage definitions: opcodes, functs, ALU/MDU encodings,
// MDU state type, control decode and operand forwarding helpers.
package e_level_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;
   localparam logic [5:0] FN_SLTU  = 6'h2b;

   typedef enum logic [3:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_SLT, ALU_SLTU, ALU_LUI, ALU_MFHI, ALU_MFLO
   } alu_op_t;

   typedef enum logic [2:0] {
      MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV,
      MDU_DIVU, MDU_MTHI, MDU_MTLO
   } mdu_op_t;

   typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_t;

   typedef enum logic [1:0] {
      DST_NONE, DST_RD, DST_RT, DST_RA
   } dst_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    use_ext;
      dst_t    dst;
      mdu_op_t mdu_op;
      logic    link;
   } ctrl_t;

   function automatic logic is_mdu_start(input mdu_op_t op);
      return op == MDU_MULT || op == MDU_MULTU ||
             op == MDU_DIV  || op == MDU_DIVU;
   endfunction

   function automatic ctrl_t cu_decode(input logic [31:0] ir);
      ctrl_t c;
      c = '0;
      unique case (ir[31:26])
         OP_RTYPE: begin
            c.dst = DST_RD;
            unique case (ir[5:0])
               FN_ADDU:  c.alu_op = ALU_ADD;
               FN_SUBU:  c.alu_op = ALU_SUB;
               FN_AND:   c.alu_op = ALU_AND;
               FN_OR:    c.alu_op = ALU_OR;
               FN_SLT:   c.alu_op = ALU_SLT;
               FN_SLTU:  c.alu_op = ALU_SLTU;
               FN_MFHI:  c.alu_op = ALU_MFHI;
               FN_MFLO:  c.alu_op = ALU_MFLO;
               FN_JALR:  c.link = 1'b1;
               FN_MULT:  begin c.mdu_op = MDU_MULT;  c.dst = DST_NONE; end
               FN_MULTU: begin c.mdu_op = MDU_MULTU; c.dst = DST_NONE; end
               FN_DIV:   begin c.mdu_op = MDU_DIV;   c.dst = DST_NONE; end
               FN_DIVU:  begin c.mdu_op = MDU_DIVU;  c.dst = DST_NONE; end
               FN_MTHI:  begin c.mdu_op = MDU_MTHI;  c.dst = DST_NONE; end
               FN_MTLO:  begin c.mdu_op = MDU_MTLO;  c.dst = DST_NONE; end
               default:  c.dst = DST_NONE;
            endcase
         end
         OP_ORI: begin
            c.alu_op  = ALU_OR;
            c.use_ext = 1'b1;
            c.dst     = DST_RT;
         end
         OP_LUI: begin
            c.alu_op = ALU_LUI;
            c.dst    = DST_RT;
         end
         OP_LW: begin
            c.alu_op  = ALU_ADD;
            c.use_ext = 1'b1;
            c.dst     = DST_RT;
         end
         OP_SW: begin
            c.alu_op  = ALU_ADD;
            c.use_ext = 1'b1;
         end
         OP_JAL: begin
            c.dst  = DST_RA;
            c.link = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // M wins over W; M only when its data is already final.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  a,
      input logic [31:0] rd,
      input logic [4:0]  m_a3,
      input logic [31:0] m_wd,
      input logic        m_wr,
      input logic        m_rdy,
      input logic [4:0]  w_a3,
      input logic [31:0] w_wd,
      input logic        w_wr
   );
      if (a == 5'd0)                         return '0;
      else if (a == m_a3 && m_wr && m_rdy)   return m_wd;
      else if (a == w_a3 && w_wr)            return w_wd;
      else                                   return rd;
   endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Only instantiated when E_LEVEL_MDU_EN is defined.
module e_mdu
   import e_level_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  mdu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   mdu_state_t  state, state_d;
   logic [CW-1:0] count, count_d;
   logic [31:0] hi_d, lo_d, a_q, a_d, b_q, b_d;
   mdu_op_t     op_q, op_d;

   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

   assign prod_u = {32'b0, a_q} * {32'b0, b_q};
   assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
                   $signed({{32{b_q[31]}}, b_q});

   // Signed divide through magnitudes: truncation toward zero and
   // dividend-signed remainder fall out, and INT_MIN/-1 is harmless.
   assign a_neg = (op_q == MDU_DIV) & a_q[31];
   assign b_neg = (op_q == MDU_DIV) & b_q[31];
   assign a_mag = a_neg ? 32'd0 - a_q : a_q;
   assign b_mag = b_neg ? 32'd0 - b_q : b_q;
   assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
   assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
   assign quo   = (a_neg ^ b_neg) ? 32'd0 - q_mag : q_mag;
   assign rem   = a_neg ? 32'd0 - r_mag : r_mag;

   always_comb begin
      state_d = state;
      count_d = count;
      hi_d    = hi;
      lo_d    = lo;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state)
         MDU_IDLE: begin
            if (is_mdu_start(op)) begin
               state_d = MDU_BUSY;
               op_d    = op;
               a_d     = a;
               b_d     = b;
               count_d = (op == MDU_MULT || op == MDU_MULTU) ?
                         CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (op == MDU_MTHI) begin
               hi_d = a;
            end else if (op == MDU_MTLO) begin
               lo_d = a;
            end
         end
         MDU_BUSY: begin
            count_d = count - CW'(1);
            if (count == CW'(1)) begin
               state_d = MDU_IDLE;
               if (op_q == MDU_MULT) begin
                  {hi_d, lo_d} = prod_s;
               end else if (op_q == MDU_MULTU) begin
                  {hi_d, lo_d} = prod_u;
               end else if (b_q != '0) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MDU_IDLE;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         op_q  <= MDU_NOP;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= state_d;
         count <= count_d;
         hi    <= hi_d;
         lo    <= lo_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/e_level.sv
// Execute stage: E pipeline register, forwarding, ALU, forward source.
// HI/LO multiply/divide support is built only with E_LEVEL_MDU_EN.
module e_level
   import e_level_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Reg_Rst,
   input  logic [31:0] IR_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] RD1_in,
   input  logic [31:0] RD2_in,
   input  logic [31:0] EXT_in,
   input  logic [4:0]  M_RFA3_in,
   input  logic [31:0] M_RFWD_in,
   input  logic        M_RFWr_in,
   input  logic        M_Forward_Ready_in,
   input  logic [4:0]  W_RFA3_in,
   input  logic [31:0] W_RFWD_in,
   input  logic        W_RFWr_in,
   output logic [31:0] IR_out,
   output logic [31:0] PC_out,
   output logic [31:0] ALU_out,
   output logic [31:0] RD2_out,
   output logic [4:0]  E_RFA3_out,
   output logic [31:0] E_RFWD_out,
   output logic        E_RFWr_out,
   output logic        E_Forward_Ready_out,
   output logic        MDU_Start_out,
   output logic        MDU_Busy_out
);

   logic [31:0] ir_q, pc_q, rd1_q, rd2_q, ext_q;
   ctrl_t       ctrl;
   logic [31:0] opa, opb, alu_b, alu;
   logic [31:0] hi, lo;
   logic [4:0]  a3;
   logic        kill, is_lui;

   always_ff @(posedge Clk) begin
      if (Rst || Reg_Rst) begin
         ir_q  <= '0;
         pc_q  <= '0;
         rd1_q <= '0;
         rd2_q <= '0;
         ext_q <= '0;
      end else begin
         ir_q  <= IR_in;
         pc_q  <= PC_in;
         rd1_q <= RD1_in;
         rd2_q <= RD2_in;
         ext_q <= EXT_in;
      end
   end

   assign ctrl = cu_decode(ir_q);

   assign opa = fwd_sel(ir_q[25:21], rd1_q,
                        M_RFA3_in, M_RFWD_in, M_RFWr_in,
                        M_Forward_Ready_in,
                        W_RFA3_in, W_RFWD_in, W_RFWr_in);
   assign opb = fwd_sel(ir_q[20:16], rd2_q,
                        M_RFA3_in, M_RFWD_in, M_RFWr_in,
                        M_Forward_Ready_in,
                        W_RFA3_in, W_RFWD_in, W_RFWr_in);

`ifdef E_LEVEL_MDU_EN
   localparam bit MDU_EN = 1'b1;

   e_mdu #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu (
      .clk (Clk),
      .rst (Rst),
      .op  (ctrl.mdu_op),
      .a   (opa),
      .b   (opb),
      .hi  (hi),
      .lo  (lo),
      .busy(MDU_Busy_out)
   );

   assign MDU_Start_out = is_mdu_start(ctrl.mdu_op);
`else
   localparam bit MDU_EN = 1'b0;

   assign hi            = '0;
   assign lo            = '0;
   assign MDU_Busy_out  = 1'b0;
   assign MDU_Start_out = 1'b0;
`endif

   // Without the MDU every HI/LO instruction degrades to a nop.
   assign kill = !MDU_EN &&
                 (ctrl.mdu_op != MDU_NOP ||
                  ctrl.alu_op == ALU_MFHI ||
                  ctrl.alu_op == ALU_MFLO);

   assign alu_b = ctrl.use_ext ? ext_q : opb;

   always_comb begin
      alu = '0;
      unique case (ctrl.alu_op)
         ALU_ADD:  alu = opa + alu_b;
         ALU_SUB:  alu = opa - alu_b;
         ALU_AND:  alu = opa & alu_b;
         ALU_OR:   alu = opa | alu_b;
         ALU_SLT:  alu = {31'b0, $signed(opa) < $signed(alu_b)};
         ALU_SLTU: alu = {31'b0, opa < alu_b};
         ALU_LUI:  alu = {ir_q[15:0], 16'b0};
         ALU_MFHI: alu = hi;
         ALU_MFLO: alu = lo;
         default:  alu = '0;
      endcase
   end

   always_comb begin
      a3 = '0;
      unique case (ctrl.dst)
         DST_RD:  a3 = ir_q[15:11];
         DST_RT:  a3 = ir_q[20:16];
         DST_RA:  a3 = 5'd31;
         default: a3 = '0;
      endcase
      if (kill) a3 = '0;
   end

   assign is_lui = (ctrl.alu_op == ALU_LUI);

   assign IR_out     = ir_q;
   assign PC_out     = pc_q;
   assign ALU_out    = kill ? '0 : alu;
   assign RD2_out    = opb;
   assign E_RFA3_out = a3;
   assign E_RFWr_out = (a3 != 5'd0);

   assign E_RFWD_out = ctrl.link ? pc_q + 32'd8 :
                       is_lui    ? {ir_q[15:0], 16'b0} : '0;
   assign E_Forward_Ready_out = ctrl.link | is_lui;

endmodule

// File: tb/tb_e_level.sv
// Directed bench for e_level; MDU checks follow E_LEVEL_MDU_EN.
module tb_e_level;

   logic        Clk, Rst, Reg_Rst;
   logic [31:0] IR_in, PC_in, RD1_in, RD2_in, EXT_in;
   logic [4:0]  M_RFA3_in, W_RFA3_in;
   logic [31:0] M_RFWD_in, W_RFWD_in;
   logic        M_RFWr_in, M_Forward_Ready_in, W_RFWr_in;
   logic [31:0] IR_out, PC_out, ALU_out, RD2_out, E_RFWD_out;
   logic [4:0]  E_RFA3_out;
   logic        E_RFWr_out, E_Forward_Ready_out;
   logic        MDU_Start_out, MDU_Busy_out;

   int vectors = 0;
   int miscompares = 0;

   e_level dut (
      .Clk                (Clk),
      .Rst                (Rst),
      .Reg_Rst            (Reg_Rst),
      .IR_in              (IR_in),
      .PC_in              (PC_in),
      .RD1_in             (RD1_in),
      .RD2_in             (RD2_in),
      .EXT_in             (EXT_in),
      .M_RFA3_in          (M_RFA3_in),
      .M_RFWD_in          (M_RFWD_in),
      .M_RFWr_in          (M_RFWr_in),
      .M_Forward_Ready_in (M_Forward_Ready_in),
      .W_RFA3_in          (W_RFA3_in),
      .W_RFWD_in          (W_RFWD_in),
      .W_RFWr_in          (W_RFWr_in),
      .IR_out             (IR_out),
      .PC_out             (PC_out),
      .ALU_out            (ALU_out),
      .RD2_out            (RD2_out),
      .E_RFA3_out         (E_RFA3_out),
      .E_RFWD_out         (E_RFWD_out),
      .E_RFWr_out         (E_RFWr_out),
      .E_Forward_Ready_out(E_Forward_Ready_out),
      .MDU_Start_out      (MDU_Start_out),
      .MDU_Busy_out       (MDU_Busy_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] rt(input logic [4:0] rs,
      input logic [4:0] rtr, input logic [4:0] rd,
      input logic [5:0] fn);
      return {6'h00, rs, rtr, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] it(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rtr,
      input logic [15:0] imm);
      return {op, rs, rtr, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [31:0] ir, input logic [31:0] pc,
      input logic [31:0] rd1, input logic [31:0] rd2,
      input logic [31:0] ext);
      IR_in  = ir;
      PC_in  = pc;
      RD1_in = rd1;
      RD2_in = rd2;
      EXT_in = ext;
      @(posedge Clk);
      #1;
   endtask

   task automatic nop();
      step(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic busy_for(input int n);
      for (int i = 0; i < n; i++) begin
         nop();
         chk("busy_on", {31'b0, MDU_Busy_out}, 32'd1);
      end
      nop();
      chk("busy_off", {31'b0, MDU_Busy_out}, 32'd0);
   endtask

   task automatic clr_fwd();
      M_RFA3_in = '0; M_RFWD_in = '0;
      M_RFWr_in = 1'b0; M_Forward_Ready_in = 1'b0;
      W_RFA3_in = '0; W_RFWD_in = '0; W_RFWr_in = 1'b0;
   endtask

   initial begin
      Rst = 1'b1;
      Reg_Rst = 1'b0;
      clr_fwd();
      step(rt(1, 2, 3, 6'h21), 32'h1234, 32'h11, 32'h22, 32'h33);
      step(it(6'h03, 0, 0, 16'h40), 32'h5678, 32'h1, 32'h2, 32'h3);
      chk("rst_ir", IR_out, 32'h0);
      chk("rst_pc", PC_out, 32'h0);
      chk("rst_alu", ALU_out, 32'h0);
      chk("rst_rd2", RD2_out, 32'h0);
      chk("rst_a3", {27'b0, E_RFA3_out}, 32'h0);
      chk("rst_wd", E_RFWD_out, 32'h0);
      chk("rst_wr", {31'b0, E_RFWr_out}, 32'h0);
      chk("rst_rdy", {31'b0, E_Forward_Ready_out}, 32'h0);
      chk("rst_start", {31'b0, MDU_Start_out}, 32'h0);
      chk("rst_busy", {31'b0, MDU_Busy_out}, 32'h0);
      Rst = 1'b0;

      step(rt(1, 2, 3, 6'h21), 32'h100, 32'hFFFFFFFF, 32'h2, 32'h0);
      chk("addu_alu", ALU_out, 32'h1);
      chk("addu_a3", {27'b0, E_RFA3_out}, 32'd3);
      chk("addu_wr", {31'b0, E_RFWr_out}, 32'd1);
      chk("addu_ir", IR_out, rt(1, 2, 3, 6'h21));
      chk("addu_pc", PC_out, 32'h100);
      chk("addu_rdy", {31'b0, E_Forward_Ready_out}, 32'd0);

      M_RFA3_in = 5'd1; M_RFWD_in = 32'd7;
      M_RFWr_in = 1'b1; M_Forward_Ready_in = 1'b1;
      W_RFA3_in = 5'd1; W_RFWD_in = 32'd9; W_RFWr_in = 1'b1;
      step(rt(1, 0, 4, 6'h23), 32'h104, 32'h55, 32'h66, 32'h0);
      chk("fwd_m", ALU_out, 32'd7);
      chk("fwd_r0_b", RD2_out, 32'd0);
      M_Forward_Ready_in = 1'b0;
      #1;
      chk("fwd_w", ALU_out, 32'd9);
      W_RFWr_in = 1'b0;
      #1;
      chk("fwd_reg", ALU_out, 32'h55);

      M_RFA3_in = 5'd0; M_RFWD_in = 32'hDEAD;
      M_RFWr_in = 1'b1; M_Forward_Ready_in = 1'b1;
      W_RFA3_in = 5'd2; W_RFWD_in = 32'hF00; W_RFWr_in = 1'b1;
      step(rt(0, 2, 5, 6'h25), 32'h108, 32'h1234, 32'hF0, 32'h0);
      chk("or_r0_w", ALU_out, 32'hF00);
      chk("or_rd2", RD2_out, 32'hF00);
      clr_fwd();

      step(rt(1, 2, 6, 6'h2a), 32'h10C, 32'hFFFFFFFF, 32'h1, 32'h0);
      chk("slt", ALU_out, 32'd1);
      step(rt(1, 2, 6, 6'h2b), 32'h110, 32'hFFFFFFFF, 32'h1, 32'h0);
      chk("sltu", ALU_out, 32'd0);
      step(rt(1, 2, 6, 6'h24), 32'h114, 32'hF0F0, 32'hFF00, 32'h0);
      chk("and", ALU_out, 32'hF000);

      step(it(6'h0d, 1, 7, 16'h8001), 32'h118,
           32'h10000, 32'h0, 32'h8001);
      chk("ori_alu", ALU_out, 32'h18001);
      chk("ori_a3", {27'b0, E_RFA3_out}, 32'd7);

      step(it(6'h0f, 0, 8, 16'h1234), 32'h11C, 32'h0, 32'h0, 32'h1234);
      chk("lui_alu", ALU_out, 32'h12340000);
      chk("lui_wd", E_RFWD_out, 32'h12340000);
      chk("lui_rdy", {31'b0, E_Forward_Ready_out}, 32'd1);
      chk("lui_a3", {27'b0, E_RFA3_out}, 32'd8);

      step(it(6'h23, 1, 9, 16'hFFFC), 32'h120,
           32'h1000, 32'h0, 32'hFFFFFFFC);
      chk("lw_addr", ALU_out, 32'hFFC);
      chk("lw_a3", {27'b0, E_RFA3_out}, 32'd9);
      chk("lw_rdy", {31'b0, E_Forward_Ready_out}, 32'd0);

      step(it(6'h2b, 1, 9, 16'h8), 32'h124, 32'h1000, 32'hCAFE, 32'h8);
      chk("sw_addr", ALU_out, 32'h1008);
      chk("sw_data", RD2_out, 32'hCAFE);
      chk("sw_wr", {31'b0, E_RFWr_out}, 32'd0);
      chk("sw_a3", {27'b0, E_RFA3_out}, 32'd0);

      step(rt(1, 2, 0, 6'h21), 32'h128, 32'h1, 32'h2, 32'h0);
      chk("r0_wr", {31'b0, E_RFWr_out}, 32'd0);

      step({6'h03, 26'h0000C10}, 32'h3000, 32'h0, 32'h0, 32'h0);
      chk("jal_wd", E_RFWD_out, 32'h3008);
      chk("jal_a3", {27'b0, E_RFA3_out}, 32'd31);
      chk("jal_rdy", {31'b0, E_Forward_Ready_out}, 32'd1);
      chk("jal_wr", {31'b0, E_RFWr_out}, 32'd1);

      Reg_Rst = 1'b1;
      step(rt(1, 2, 3, 6'h21), 32'h200, 32'h5, 32'h6, 32'h0);
      chk("flush_ir", IR_out, 32'h0);
      chk("flush_pc", PC_out, 32'h0);
      chk("flush_alu", ALU_out, 32'h0);
      Reg_Rst = 1'b0;

`ifdef E_LEVEL_MDU_EN
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("hi_rst", ALU_out, 32'h0);

      step(rt(1, 2, 0, 6'h18), 32'h0, 32'hFFFFFFFF, 32'h2, 32'h0);
      chk("mult_start", {31'b0, MDU_Start_out}, 32'd1);
      chk("mult_idle", {31'b0, MDU_Busy_out}, 32'd0);
      busy_for(5);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("mult_hi", ALU_out, 32'hFFFFFFFF);
      chk("mfhi_a3", {27'b0, E_RFA3_out}, 32'd10);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("mult_lo", ALU_out, 32'hFFFFFFFE);

      step(rt(1, 2, 0, 6'h19), 32'h0, 32'hFFFFFFFF, 32'h2, 32'h0);
      busy_for(5);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("multu_hi", ALU_out, 32'h1);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("multu_lo", ALU_out, 32'hFFFFFFFE);

      step(rt(1, 2, 0, 6'h1a), 32'h0, 32'hFFFFFFF9, 32'h2, 32'h0);
      busy_for(10);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("div_lo", ALU_out, 32'hFFFFFFFD);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("div_hi", ALU_out, 32'hFFFFFFFF);

      step(rt(1, 2, 0, 6'h1a), 32'h0, 32'h5, 32'h0, 32'h0);
      busy_for(10);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("div0_lo", ALU_out, 32'hFFFFFFFD);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("div0_hi", ALU_out, 32'hFFFFFFFF);

      step(rt(1, 0, 0, 6'h11), 32'h0, 32'hABCD, 32'h0, 32'h0);
      step(rt(1, 0, 0, 6'h13), 32'h0, 32'h1234, 32'h0, 32'h0);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("mthi", ALU_out, 32'hABCD);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("mtlo", ALU_out, 32'h1234);

      step(rt(1, 2, 0, 6'h1a), 32'h0, 32'd100, 32'd7, 32'h0);
      for (int i = 0; i < 3; i++) begin
         nop();
         chk("rst_div_busy", {31'b0, MDU_Busy_out}, 32'd1);
      end
      Rst = 1'b1;
      nop();
      chk("rst_mid_busy", {31'b0, MDU_Busy_out}, 32'd0);
      Rst = 1'b0;
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("rst_mid_hi", ALU_out, 32'h0);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("rst_mid_lo", ALU_out, 32'h0);

      step(rt(1, 2, 0, 6'h1a), 32'h0, 32'd100, 32'd7, 32'h0);
      for (int i = 0; i < 3; i++) begin
         nop();
         chk("flush_div_busy", {31'b0, MDU_Busy_out}, 32'd1);
      end
      Reg_Rst = 1'b1;
      nop();
      chk("flush_mid_busy", {31'b0, MDU_Busy_out}, 32'd1);
      Reg_Rst = 1'b0;
      busy_for(6);
      step(rt(0, 0, 10, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("flush_div_lo", ALU_out, 32'd14);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("flush_div_hi", ALU_out, 32'd2);
`else
      step(rt(1, 2, 0, 6'h18), 32'h0, 32'hFFFFFFFF, 32'h2, 32'h0);
      chk("nomdu_start", {31'b0, MDU_Start_out}, 32'd0);
      nop();
      chk("nomdu_busy", {31'b0, MDU_Busy_out}, 32'd0);
      step(rt(0, 0, 10, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk("nomdu_mfhi", ALU_out, 32'h0);
      chk("nomdu_wr", {31'b0, E_RFWr_out}, 32'd0);
      chk("nomdu_a3", {27'b0, E_RFA3_out}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/e_level.md
E_LEVEL -- requirements
Module: e_level

Interface
REQ-001 Parameter MULT_CYCLES, default 5, cycles from mult/multu issue to HI/LO valid.
REQ-002 Parameter DIV_CYCLES, default 10, cycles from div/divu issue to HI/LO valid.
REQ-003 Ports SHALL be: Clk  in  1  single clock, all state on rising edge; Rst  in  1  reset, synchronous, active-high.
REQ-004 Reg_Rst  in  1  E pipeline-register flush: bubble insert, synchronous, active-high.
REQ-005 IR_in, PC_in, RD1_in, RD2_in, EXT_in  in  32 each  instruction, PC, register operands, extended immediate from decode.
REQ-006 M_RFA3_in 5, M_RFWD_in 32, M_RFWr_in 1, M_Forward_Ready_in 1  in  memory-stage forward source.
REQ-007 W_RFA3_in 5, W_RFWD_in 32, W_RFWr_in 1  in  writeback-stage forward source.
REQ-008 IR_out, PC_out  out  32  registered instruction and PC passed to memory stage.
REQ-009 ALU_out  out  32  ALU/address/HI/LO result; RD2_out  out  32  forwarded rt value (store data).
REQ-010 E_RFA3_out 5, E_RFWD_out 32, E_RFWr_out 1, E_Forward_Ready_out 1  out  forward source presented to decode.
REQ-011 MDU_Start_out  out  1  E holds mult/multu/div/divu; MDU_Busy_out  out  1  MDU computing.

Function
REQ-012 E register SHALL latch IR/PC/RD1/RD2/EXT every edge (no stall input); Rst or Reg_Rst loads all zeros (nop, PC 0).
REQ-013 Operand A (rs), B (rt) SHALL select: reg 0 -> 0; else M match & M_RFWr & M_Forward_Ready -> M_RFWD; else W match & W_RFWr -> W_RFWD; else latched RD; M has priority over W.
REQ-014 ALU SHALL implement addu, subu, and, or, slt (signed), sltu, ori, lui, lw/sw address (A+EXT); arithmetic modulo 2^32, no overflow trap.
REQ-015 ALU second operand SHALL be B for R-type, EXT for I-type; mfhi/mflo SHALL drive ALU_out with HI/LO.
REQ-016 E_RFA3_out SHALL be rd (R-type writes), rt (I-type writes), 31 (jal), 0 otherwise; E_RFWr_out high iff A3 nonzero and instruction writes.
REQ-017 E_RFWD_out SHALL be PC+8 for jal/jalr, {imm,16'b0} for lui; E_Forward_Ready_out high only for those, else 0.
REQ-018 MDU states IDLE/BUSY; IDLE + start op at edge -> capture A,B, count=MULT_CYCLES or DIV_CYCLES, go BUSY.
REQ-019 BUSY: count decrements each edge; edge where count 1->0 writes HI/LO and returns IDLE; Busy high exactly MULT_CYCLES/DIV_CYCLES cycles after start edge.
REQ-020 mult/multu: {HI,LO}=64-bit product; div/divu: LO=quotient truncated toward zero, HI=remainder with dividend sign.
REQ-021 Divisor 0: HI, LO SHALL remain unchanged; Busy timing unaffected.
REQ-022 mthi/mtlo SHALL write HI/LO from A at the edge they occupy E.
REQ-023 Start op or mthi/mtlo arriving while BUSY SHALL be ignored (hazard unit prevents it).
REQ-024 MDU_Start_out combinational from latched IR, independent of Busy.

Reset
REQ-025 Rst SHALL zero E register, HI, LO, count, force IDLE, mid-operation included; all outputs then 0.
REQ-026 Reg_Rst SHALL NOT affect HI, LO, count or state; in-flight MDU op completes.

Configuration
REQ-027 Macro E_LEVEL_MDU_EN defined: MDU, HI/LO, mult/div/mfhi/mflo/mthi/mtlo as above.
REQ-028 Undefined: no HI/LO storage; MDU_Start_out, MDU_Busy_out tied 0; those opcodes execute as nop (ALU_out 0, E_RFWr_out 0).

Structure
REQ-029 Shared package SHALL hold opcode/funct constants, ALUOp and MDUOp encodings, MDU state type.
REQ-030 MDU SHALL be sub-module e_mdu (state, counter, HI/LO); decode reuses shared CU.

Verification
REQ-031 addu $3,$1,$2 with $1=0xFFFFFFFF, $2=2 -> ALU_out=0x00000001, E_RFA3_out=3.
REQ-032 M forwards $1=7 (ready) while W forwards $1=9, subu $4,$1,$0 -> ALU_out=7.
REQ-033 mult 0xFFFFFFFF x 2 -> Busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=1, LO=0xFFFFFFFE.
REQ-034 div -7/2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divisor 0 -> HI/LO unchanged.
REQ-035 Rst at 3rd Busy cycle of div -> next cycle Busy=0, HI=LO=0; Reg_Rst same point -> div completes on schedule.
REQ-036 jal at PC 0x3000 -> E_RFWD_out=0x3008, E_RFA3_out=31, E_Forward_Ready_out=1.
